rgmii_tx_framer: RTL and testbench
==================================

// Module: rgmii_tx_framer
// PURPOSE
//  Transmit side of the RGMII MAC path; counterpart of the DDR-input receive path.
//  - Input: an AXI-Stream byte frame.
//  - Adds 7x0x55 preamble and the 0xD5 SFD, pads to the minimum length, appends the
//    CRC32 FCS, then enforces the inter-frame gap.
//  - Output: per-clock rising/falling nibble and control pairs that feed the ODDR
//    output registers directly. 1 Gb/s, one byte per clk.
// PARAMETERS
//  MIN_FRAME_BYTES  60  minimum bytes before FCS; shorter frames are zero-padded
//  IFG_BYTES        12  idle cycles forced after FCS (or after an abort)
//  CNT_W            16  payload byte counter width; counter saturates
// PORTS
//  clk            in   1  single clock; all logic on posedge
//  rst            in   1  synchronous, active-high reset
//  s_axis_tdata   in   8  payload byte
//  s_axis_tvalid  in   1  byte valid
//  s_axis_tready  out  1  byte accepted when tvalid&tready
//  s_axis_tlast   in   1  last payload byte of the frame
//  s_axis_tuser   in   1  byte error; that byte is sent with TX_ER
//  rgmii_d1       out  4  rising-edge nibble = byte[3:0]
//  rgmii_d2       out  4  falling-edge nibble = byte[7:4]
//  rgmii_ctl1     out  1  rising-edge TX_CTL = TX_EN
//  rgmii_ctl2     out  1  falling-edge TX_CTL = TX_EN ^ TX_ER
//  busy           out  1  high in every state except IDLE
//  frame_done     out  1  one-cycle pulse on the cycle the last FCS byte is driven
// BEHAVIOUR
//  Reset
//  - All outputs 0, state IDLE, CRC = 32'hFFFFFFFF, counters 0.
//  - A reset mid-frame truncates the frame: outputs read 0 on the cycle after rst is sampled.
//  Output timing
//  - All rgmii_* outputs are registered. A byte selected in cycle N is driven in N+1.
//  - Idle encoding: d1=d2=0, ctl1=ctl2=0.
//  States
//  - IDLE: tready=0. When tvalid=1 (nothing consumed), go to PRE.
//  - PRE: 8 cycles. Counter 0..6 drives 0x55, counter 7 drives 0xD5. Then go to DATA.
//    CRC is reset to all-ones here.
//  - DATA: tready=1. On each beat:
//    - drive tdata with ctl1=1 and ctl2=~tuser;
//    - CRC and byte count are updated on every beat, including error bytes.
//    - On tlast: go to PAD if count+1 < MIN_FRAME_BYTES, else go to FCS.
//  - DATA underrun (tvalid=0):
//    - drive 0x00 with ctl1=1, ctl2=0 (TX_ER);
//    - no FCS is sent; go to DROP, or to IFG if that beat was last.
//  - DROP: tready=1. Discard beats up to and including tlast, driving idle. Then go to IFG.
//  - PAD: drive 0x00 (ctl 1/1), CRC updated, until count == MIN_FRAME_BYTES. Then go to FCS.
//  - FCS: 4 cycles driving ~CRC, bytes [7:0],[15:8],[23:16],[31:24].
//    frame_done pulses with the 4th byte. Then go to IFG.
//  - IFG: IFG_BYTES cycles, idle, tready=0. Then go to IDLE.
//    A tvalid held through IFG starts PRE in the cycle after IDLE samples it.
//  Other rules
//  - CRC: reflected poly 32'hEDB88320, byte-wise, LSB first, init all-ones, final complement.
//  - tlast seen in PRE/IFG/IDLE is ignored; tready=0 there, so nothing is consumed.
//  - Byte counter saturates at 2^CNT_W-1. Jumbo frames are legal; no max-length check.
//  - tvalid dropping between frames is legal and has no effect.
// STRUCTURE
//  - Package eth_pkg:
//    - tx_state_t enum {IDLE,PRE,DATA,DROP,PAD,FCS,IFG};
//    - ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF.
//  - Sub-module eth_crc32_byte: combinational (crc_in[31:0], data[7:0]) -> crc_out[31:0].
//    Shared with the receive-side FCS checker.
//  - Top: FSM, byte/pad/IFG counters, output register stage.
// TESTING
//  1. Reset: rst held 3 cycles, tvalid=1 -> all outputs 0, tready=0, busy=0.
//     Release -> PRE starts the next cycle.
//  2. 60-byte frame 0x00..0x3B -> ctl1=1 for exactly 72 cycles:
//     - 8 preamble/SFD, 60 data, 4 FCS; FCS matches the reference CRC model;
//     - frame_done is 1 cycle; then 12 idle cycles.
//  3. eth_crc32_byte unit test: ASCII "123456789" from all-ones, final complement
//     -> 0xCBF43926, emitted order 26,39,F4,CB.
//  4. 14-byte frame -> 46 0x00 pad bytes with ctl 1/1, FCS over 60 bytes,
//     72 TX_EN cycles total.
//  5. Underrun: tvalid low at byte 20 of 100 -> byte 20 = 0x00 with ctl1=1/ctl2=0;
//     - no FCS;
//     - bytes 21..99 consumed with rgmii idle;
//     - 12 IFG cycles after tlast.
//  6. Errors, back-to-back, reset:
//     - tuser=1 on byte 5 -> only that cycle has ctl2=0; FCS is still appended.
//     - Back-to-back frames with tvalid always 1 -> exactly 12 idle cycles plus
//       1 IDLE cycle between the last FCS byte and the next 0x55.
//     - rst pulse mid-DATA -> outputs 0 on the next cycle.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: transmit FSM states and framing/CRC constants.
package eth_pkg;

  typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, PAD, FCS, IFG} tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;
  localparam int          ETH_PRE_LEN  = 8;
  localparam int          ETH_FCS_LEN  = 4;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC32 (LSB first), purely combinational.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[31:1]} ^ (c[0] ? ETH_CRC_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: preamble/SFD, padding, FCS and inter-frame gap around an
// AXI-Stream byte frame; emits rising/falling nibble and control pairs for ODDRs.
module rgmii_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] rgmii_d1,
  output logic [3:0] rgmii_d2,
  output logic       rgmii_ctl1,
  output logic       rgmii_ctl2,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   MIN_LEN  = (CNT_W+1)'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(ETH_PRE_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(ETH_FCS_LEN - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);

  tx_state_t        state, state_nx;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nx;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_nx;
  logic [CNT_W:0]   cnt_inc;
  logic [31:0]      crc, crc_nx, crc_upd, crc_fin;
  logic [7:0]       crc_data;
  logic [7:0]       byte_p0;
  logic             en_p0, er_p0, done_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_upd)
  );

  assign crc_data      = (state == PAD) ? 8'h00 : s_axis_tdata;
  assign crc_fin       = ~crc;
  // Count including the current beat, one bit wider so a saturated count cannot wrap.
  assign cnt_inc       = (CNT_W+1)'(byte_cnt) + (CNT_W+1)'(1);
  assign s_axis_tready = (state == DATA) || (state == DROP);
  assign busy          = (state != IDLE);

  always_comb begin
    state_nx     = state;
    byte_cnt_nx  = byte_cnt;
    phase_cnt_nx = phase_cnt;
    crc_nx       = crc;
    byte_p0      = 8'h00;
    en_p0        = 1'b0;
    er_p0        = 1'b0;
    done_p0      = 1'b0;
    case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_nx     = PRE;
          phase_cnt_nx = '0;
        end
      end
      PRE: begin
        en_p0       = 1'b1;
        byte_p0     = (phase_cnt == PRE_LAST) ? ETH_SFD : ETH_PREAMBLE;
        crc_nx      = ETH_CRC_INIT;
        byte_cnt_nx = '0;
        if (phase_cnt == PRE_LAST) begin
          state_nx     = DATA;
          phase_cnt_nx = '0;
        end else begin
          phase_cnt_nx = phase_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        en_p0 = 1'b1;
        if (s_axis_tvalid) begin
          byte_p0     = s_axis_tdata;
          er_p0       = s_axis_tuser;
          crc_nx      = crc_upd;
          byte_cnt_nx = sat_inc(byte_cnt);
          if (s_axis_tlast) begin
            state_nx     = (cnt_inc < MIN_LEN) ? PAD : FCS;
            phase_cnt_nx = '0;
          end
        end else begin
          // Underrun: poison the frame with TX_ER and never send an FCS for it.
          er_p0        = 1'b1;
          state_nx     = s_axis_tlast ? IFG : DROP;
          phase_cnt_nx = '0;
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nx     = IFG;
          phase_cnt_nx = '0;
        end
      end
      PAD: begin
        en_p0       = 1'b1;
        crc_nx      = crc_upd;
        byte_cnt_nx = sat_inc(byte_cnt);
        if (cnt_inc >= MIN_LEN) begin
          state_nx     = FCS;
          phase_cnt_nx = '0;
        end
      end
      FCS: begin
        en_p0 = 1'b1;
        case (phase_cnt[1:0])
          2'd0:    byte_p0 = crc_fin[7:0];
          2'd1:    byte_p0 = crc_fin[15:8];
          2'd2:    byte_p0 = crc_fin[23:16];
          default: byte_p0 = crc_fin[31:24];
        endcase
        if (phase_cnt == FCS_LAST) begin
          done_p0      = 1'b1;
          state_nx     = IFG;
          phase_cnt_nx = '0;
        end else begin
          phase_cnt_nx = phase_cnt + CNT_W'(1);
        end
      end
      IFG: begin
        if (phase_cnt == IFG_LAST) begin
          state_nx     = IDLE;
          phase_cnt_nx = '0;
        end else begin
          phase_cnt_nx = phase_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0 -> output registers feeding the ODDR pair
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      phase_cnt  <= '0;
      crc        <= ETH_CRC_INIT;
      rgmii_d1   <= 4'h0;
      rgmii_d2   <= 4'h0;
      rgmii_ctl1 <= 1'b0;
      rgmii_ctl2 <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_cnt_nx;
      phase_cnt  <= phase_cnt_nx;
      crc        <= crc_nx;
      rgmii_d1   <= byte_p0[3:0];
      rgmii_d2   <= byte_p0[7:4];
      rgmii_ctl1 <= en_p0;
      rgmii_ctl2 <= en_p0 ^ er_p0;
      frame_done <= done_p0;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Bench for rgmii_tx_framer: directed scenarios with random payloads, compared per
// cycle against a frame-level reference of the expected wire sequence.
module tb_rgmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser;
  logic       tready;
  logic [3:0] rgmii_d1, rgmii_d2;
  logic       rgmii_ctl1, rgmii_ctl2, busy, frame_done;

  logic [31:0] cu_in, cu_out;
  logic [7:0]  cu_data;

  int checks   = 0;
  int failures = 0;

  logic [11:0] log_q[$];
  logic [11:0] exp_q[$];
  logic [7:0]  pl[$];
  logic [7:0]  pa[$];
  logic [7:0]  pb[$];
  int          err_at = -1;
  int          gap_at = -1;

  rgmii_tx_framer #(.MIN_FRAME_BYTES(60), .IFG_BYTES(12), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .s_axis_tuser  (tuser),
    .rgmii_d1      (rgmii_d1),
    .rgmii_d2      (rgmii_d2),
    .rgmii_ctl1    (rgmii_ctl1),
    .rgmii_ctl2    (rgmii_ctl2),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  eth_crc32_byte u_crc_unit (
    .crc_in  (cu_in),
    .data    (cu_data),
    .crc_out (cu_out)
  );

  always #5 clk = ~clk;

  // Word layout: {busy, frame_done, ctl1, ctl2, byte}
  function automatic logic [11:0] cur_word();
    return {busy, frame_done, rgmii_ctl1, rgmii_ctl2, rgmii_d2, rgmii_d1};
  endfunction

  always @(negedge clk) log_q.push_back(cur_word());

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void push_w(input logic b, input logic d, input logic e, input logic c,
                                 input logic [7:0] v);
    exp_q.push_back({b, d, e, c, v});
  endfunction

  function automatic void model_preamble();
    for (int i = 0; i < 7; i++) push_w(1, 0, 1, 1, 8'h55);
    push_w(1, 0, 1, 1, 8'hD5);
  endfunction

  // Good frame: preamble, payload (TX_ER on err_at), zero pad to 60, FCS, then the
  // gap: 11 more IFG cycles after the last FCS byte, one IDLE, and PRE if back-to-back.
  function automatic void model_good(input bit b2b);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    model_preamble();
    foreach (pl[i]) begin
      fr.push_back(pl[i]);
      push_w(1, 0, 1, (i == err_at) ? 1'b0 : 1'b1, pl[i]);
    end
    while (fr.size() < 60) begin
      fr.push_back(8'h00);
      push_w(1, 0, 1, 1, 8'h00);
    end
    fcs = ref_fcs(fr);
    for (int b = 0; b < 4; b++) push_w(1, (b == 3), 1, 1, fcs[8*b +: 8]);
    repeat (11) push_w(1, 0, 0, 0, 8'h00);
    push_w(0, 0, 0, 0, 8'h00);
    if (b2b) push_w(1, 0, 0, 0, 8'h00);
  endfunction

  // Underrun: the gap beat carries 0x00 with TX_ER, the rest of the frame is dropped
  // silently, then 12 IFG cycles follow the beat that carried tlast.
  function automatic void model_underrun();
    model_preamble();
    for (int i = 0; i < gap_at; i++) push_w(1, 0, 1, 1, pl[i]);
    push_w(1, 0, 1, 0, 8'h00);
    repeat (pl.size() - gap_at - 1 + 12) push_w(1, 0, 0, 0, 8'h00);
    push_w(0, 0, 0, 0, 8'h00);
  endfunction

  task automatic send_frame();
    int idx = 0;
    int budget = 0;
    bit gap_done = 0;
    while (idx < pl.size() && budget < 2000) begin
      @(negedge clk);
      if (idx == gap_at && !gap_done && tready) begin
        tvalid = 0; tlast = 0; tuser = 0; tdata = 8'($urandom);
        gap_done = 1;
      end else begin
        tvalid = 1; tdata = pl[idx]; tlast = (idx == pl.size() - 1); tuser = (idx == err_at);
      end
      if (tvalid && tready) idx++;
      budget++;
    end
    @(posedge clk);
    check("bytes_consumed", idx, pl.size());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 0; tlast = 0; tuser = 0;
    end
  endtask

  task automatic clear_log();
    @(posedge clk);
    #1;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic compare_log(input string tag, output int start);
    start = -1;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i][9]) begin start = i; break; end
    check({tag, "_frame_seen"}, 32'(start >= 0), 32'd1);
    if (start >= 0)
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("%s_w%0d", tag, i),
              (start + i < log_q.size()) ? 32'(log_q[start + i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  function automatic int count_en();
    int n = 0;
    foreach (log_q[i]) if (log_q[i][9]) n++;
    return n;
  endfunction

  initial begin
    string s = "123456789";
    int    st, d_idx, n_idx;
    int    lens[3] = '{1, 59, 61};
    rst = 1; tvalid = 1; tdata = 8'h00; tlast = 0; tuser = 0;

    // CRC byte step over "123456789" from all-ones
    cu_in = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      cu_data = s[i];
      #1;
      cu_in = cu_out;
    end
    check("crc_check_value", ~cu_in, 32'hCBF43926);

    // Reset held with tvalid high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {tready, cur_word()}, 13'h0);
    @(posedge clk);
    #1;
    rst = 0;
    log_q.delete();
    exp_q.delete();

    // 60-byte counting frame straight out of reset
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    err_at = -1; gap_at = -1;
    model_good(0);
    send_frame();
    idle(40);
    compare_log("f60", st);
    check("f60_start_after_reset", st, 2);
    check("f60_pre_busy", (st >= 1) ? 32'(log_q[st - 1]) : 32'hDEAD, 32'h800);
    check("f60_en_cycles", count_en(), 72);

    // Short frame padded to the minimum length
    clear_log();
    rand_payload(14);
    model_good(0);
    send_frame();
    idle(80);
    compare_log("f14", st);
    check("f14_en_cycles", count_en(), 72);

    // Boundary lengths around the minimum plus one random length
    for (int k = 0; k < 4; k++) begin
      clear_log();
      rand_payload((k < 3) ? lens[k] : $urandom_range(20, 120));
      model_good(0);
      send_frame();
      idle(90);
      compare_log($sformatf("len%0d", pl.size()), st);
    end

    // Underrun at byte 20 of 100
    clear_log();
    rand_payload(100);
    gap_at = 20;
    model_underrun();
    send_frame();
    idle(20);
    compare_log("underrun", st);
    check("underrun_en_cycles", count_en(), 8 + 21);
    gap_at = -1;

    // Errored byte 5 still gets an FCS
    clear_log();
    rand_payload($urandom_range(30, 90));
    err_at = 5;
    model_good(0);
    send_frame();
    idle(80);
    compare_log("tuser", st);
    err_at = -1;

    // Back-to-back frames with tvalid held high
    clear_log();
    rand_payload($urandom_range(10, 50)); pa = pl;
    rand_payload($urandom_range(61, 90)); pb = pl;
    pl = pa; model_good(1);
    pl = pb; model_good(0);
    pl = pa; send_frame();
    pl = pb; send_frame();
    idle(40);
    compare_log("b2b", st);
    d_idx = -1; n_idx = -1;
    foreach (log_q[i]) if (d_idx < 0 && log_q[i][10]) d_idx = i;
    if (d_idx >= 0)
      for (int i = d_idx + 1; i < log_q.size(); i++)
        if (log_q[i][9]) begin n_idx = i; break; end
    check("b2b_idle_gap", n_idx - d_idx - 1, 13);

    // Reset pulse in the middle of DATA, then recovery
    clear_log();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tvalid = 1; tdata = 8'($urandom); tlast = 0; tuser = 0;
    end
    check("mid_data_en", rgmii_ctl1, 1'b1);
    rst = 1;
    @(negedge clk);
    check("mid_reset_outputs", {tready, cur_word()}, 13'h0);
    rst = 0;
    tvalid = 0;
    idle(5);
    clear_log();
    rand_payload(70);
    model_good(0);
    send_frame();
    idle(30);
    compare_log("recover", st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
